// File: rtl/wb_init_pkg.sv
// Shared definitions for the Wishbone logic-analyzer initiator.
// Contents:
//   ADR_W/DAT_W/SEL_W  Wishbone address, data and byte-select widths
//   state_t            initiator FSM encoding (IDLE -> BUS -> RESP -> IDLE)
//   wb_req_t           captured command, driven onto the wbm_* bus registers
package wb_init_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_la_initiator_if.sv
// Bundle of the command, response and Wishbone master signals of the initiator.
// Modports:
//   master  the initiator itself: takes commands, drives the WB cycle, returns responses
//   slave   the environment: command source, response sink and the WB target
interface wb_la_initiator_if;
    import wb_init_pkg::*;

    // Command port
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_we_i;
    logic [SEL_W-1:0] cmd_sel_i;
    logic [ADR_W-1:0] cmd_adr_i;
    logic [DAT_W-1:0] cmd_dat_i;

    // Response port
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [DAT_W-1:0] rsp_dat_o;
    logic             rsp_err_o;

    // Wishbone classic master
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [SEL_W-1:0] wbm_sel_o;
    logic [ADR_W-1:0] wbm_adr_o;
    logic [DAT_W-1:0] wbm_dat_o;
    logic [DAT_W-1:0] wbm_dat_i;
    logic             wbm_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog counter.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear to 0 (has priority over en)
//   en          count up by one
//   tc          high while the count equals TIMEOUT_CYCLES-1
module wb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/wb_la_initiator.sv
// Wishbone classic single-transfer initiator driven from logic-analyzer bits.
// Each accepted command issues exactly one WB cycle; the result (read data,
// or zero for writes/timeouts) is held on the response port until consumed.
// Ports:
//   wb_clk_i   clock
//   wb_rst_ni  asynchronous reset, active-low; drops cyc/stb immediately
//   busy_o     high while in BUS or RESP
//   bus        command / response / Wishbone master bundle (master modport)
// Every output comes straight from a flop: there is no input-to-output path.
module wb_la_initiator
    import wb_init_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    output logic                  busy_o,
    wb_la_initiator_if.master     bus
);

    state_t           state_q, state_d;
    wb_req_t          req_q, req_d;
    logic             cyc_q, cyc_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;

    logic in_bus;
    logic cnt_tc;

    // The watchdog sits at 0 outside BUS so it starts from 0 on every cycle.
    assign in_bus = (state_q == ST_BUS);

    wb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout_cnt (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .clr   (!in_bus),
        .en    (in_bus),
        .tc    (cnt_tc)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cyc_d       = cyc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready_q is low for the first cycle after reset release.
                if (bus.cmd_valid_i && cmd_ready_q) begin
                    req_d.we  = bus.cmd_we_i;
                    req_d.sel = bus.cmd_sel_i;
                    req_d.adr = bus.cmd_adr_i;
                    req_d.dat = bus.cmd_dat_i;
                    cyc_d     = 1'b1;
                    state_d   = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack is checked first so an ack on the terminal-count cycle wins.
                if (bus.wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = req_q.we ? '0 : bus.wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (cnt_tc) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // with the state they describe.
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            cyc_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cyc_q       <= cyc_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.wbm_cyc_o   = cyc_q;
    assign bus.wbm_stb_o   = cyc_q;
    assign bus.wbm_we_o    = req_q.we;
    assign bus.wbm_sel_o   = req_q.sel;
    assign bus.wbm_adr_o   = req_q.adr;
    assign bus.wbm_dat_o   = req_q.dat;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_wb_la_initiator.sv
// Directed self-checking bench for wb_la_initiator (TIMEOUT_CYCLES = 4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_wb_la_initiator;

    logic clk;
    logic rst_n;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;

    wb_la_initiator_if bus ();

    wb_la_initiator #(
        .TIMEOUT_CYCLES (4),
        .TO_W           (16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .busy_o    (busy),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge (accepted when the DUT is idle and ready).
    task automatic send_cmd(input logic we, input logic [3:0] sel,
                            input logic [31:0] adr, input logic [31:0] dat);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_sel_i   = sel;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic consume();
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
    endtask

    // Hard stop so a broken DUT can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int stb_cycles;

        rst_n           = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_sel_i   = '0;
        bus.cmd_adr_i   = '0;
        bus.cmd_dat_i   = '0;
        bus.rsp_ready_i = 1'b0;
        bus.wbm_dat_i   = '0;
        bus.wbm_ack_i   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_cyc",       32'(bus.wbm_cyc_o),   32'd0);
        check("rst_stb",       32'(bus.wbm_stb_o),   32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_busy",      32'(busy),            32'd0);
        check("rst_adr",       bus.wbm_adr_o,        32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);

        // ---------------- read, ack one cycle after stb ----------------
        send_cmd(1'b0, 4'hF, 32'h3000_0000, 32'h0);
        check("rd_stb",       32'(bus.wbm_stb_o),   32'd1);
        check("rd_cyc",       32'(bus.wbm_cyc_o),   32'd1);
        check("rd_we",        32'(bus.wbm_we_o),    32'd0);
        check("rd_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
        check("rd_busy",      32'(busy),            32'd1);
        tick();
        check("rd_wait_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rd_wait_stb",   32'(bus.wbm_stb_o),   32'd1);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'hA5A5_0001;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("rd_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("rd_rsp_dat",   bus.rsp_dat_o,        32'hA5A5_0001);
        check("rd_rsp_err",   32'(bus.rsp_err_o),   32'd0);
        check("rd_cyc_drop",  32'(bus.wbm_cyc_o),   32'd0);
        consume();
        check("rd_rsp_clear", 32'(bus.rsp_valid_o), 32'd0);
        check("rd_ready_back", 32'(bus.cmd_ready_o), 32'd1);

        // ---------------- write, zero-wait ack ----------------
        send_cmd(1'b1, 4'hF, 32'h3000_0004, 32'h1234_5678);
        check("wr_adr", bus.wbm_adr_o,      32'h3000_0004);
        check("wr_dat", bus.wbm_dat_o,      32'h1234_5678);
        check("wr_sel", 32'(bus.wbm_sel_o), 32'hF);
        check("wr_we",  32'(bus.wbm_we_o),  32'd1);
        check("wr_stb", 32'(bus.wbm_stb_o), 32'd1);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'hDEAD_BEEF;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("wr_stb_one_cycle", 32'(bus.wbm_stb_o),   32'd0);
        check("wr_rsp_valid",     32'(bus.rsp_valid_o), 32'd1);
        check("wr_rsp_dat",       bus.rsp_dat_o,        32'd0);
        check("wr_rsp_err",       32'(bus.rsp_err_o),   32'd0);
        check("wr_adr_hold",      bus.wbm_adr_o,        32'h3000_0004);
        consume();

        // ---------------- ack outside BUS is ignored ----------------
        bus.wbm_ack_i = 1'b1;
        tick();
        tick();
        bus.wbm_ack_i = 1'b0;
        check("stray_ack_cyc",   32'(bus.wbm_cyc_o),   32'd0);
        check("stray_ack_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("stray_ack_busy",  32'(busy),            32'd0);
        check("stray_ack_ready", 32'(bus.cmd_ready_o), 32'd1);

        // ---------------- timeout, no ack ----------------
        bus.wbm_dat_i = 32'hFFFF_FFFF;
        send_cmd(1'b0, 4'h3, 32'h3000_000C, 32'h0);
        stb_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid_o) break;
            if (bus.wbm_stb_o) stb_cycles++;
            tick();
        end
        check("to_stb_cycles", 32'(stb_cycles),       32'd4);
        check("to_rsp_valid",  32'(bus.rsp_valid_o), 32'd1);
        check("to_stb_drop",   32'(bus.wbm_stb_o),   32'd0);
        check("to_rsp_err",    32'(bus.rsp_err_o),   32'd1);
        check("to_rsp_dat",    bus.rsp_dat_o,        32'd0);
        consume();

        // ---------------- ack on the terminal-count cycle ----------------
        send_cmd(1'b0, 4'hF, 32'h3000_0008, 32'h0);
        tick();
        tick();
        tick();
        check("tc_stb_still_high", 32'(bus.wbm_stb_o), 32'd1);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'hC0FF_EE01;
        tick();
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'h0;
        check("tc_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("tc_rsp_err",   32'(bus.rsp_err_o),   32'd0);
        check("tc_rsp_dat",   bus.rsp_dat_o,        32'hC0FF_EE01);

        // ---------------- response stall with a pending command ----------------
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_sel_i   = 4'hF;
        bus.cmd_adr_i   = 32'h3000_0010;
        bus.cmd_dat_i   = 32'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", 32'(bus.rsp_valid_o), 32'd1);
            check("stall_dat",   bus.rsp_dat_o,        32'hC0FF_EE01);
            check("stall_err",   32'(bus.rsp_err_o),   32'd0);
            check("stall_ready", 32'(bus.cmd_ready_o), 32'd0);
            check("stall_cyc",   32'(bus.wbm_cyc_o),   32'd0);
        end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        check("stall_release_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("stall_release_ready", 32'(bus.cmd_ready_o), 32'd1);
        tick();
        bus.cmd_valid_i = 1'b0;
        check("held_cmd_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        check("held_cmd_adr", bus.wbm_adr_o,      32'h3000_0010);

        // ---------------- reset pulsed mid-BUS ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cyc",  32'(bus.wbm_cyc_o), 32'd0);
        check("midrst_stb",  32'(bus.wbm_stb_o), 32'd0);
        check("midrst_busy", 32'(busy),          32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("postrst_busy",  32'(busy),            32'd0);

        // New read after reset, with all byte selects off.
        send_cmd(1'b0, 4'h0, 32'h3000_0020, 32'h0);
        check("sel0_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        check("sel0_sel", 32'(bus.wbm_sel_o), 32'd0);
        check("sel0_adr", bus.wbm_adr_o,      32'h3000_0020);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h5A5A_1234;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("postrst_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("postrst_rsp_dat",   bus.rsp_dat_o,        32'h5A5A_1234);
        check("postrst_rsp_err",   32'(bus.rsp_err_o),   32'd0);
        consume();
        check("final_idle_ready", 32'(bus.cmd_ready_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
